fb_uart_dump: RTL and testbench

//  Reads the 4-bit frame buffer (X_MAX*Y_MAX pixels, row-major) out of the shared BRAM and streams it over

---
 rtl/fb_pkg.sv | 51 +++++
 rtl/fb_uart_byte_sender.sv | 82 ++++++++
 rtl/fb_uart_dump.sv | 211 +++++++++++++++++++++
 tb/tb_fb_uart_dump.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the frame-buffer UART dump block.
//   FB_SYNC0/FB_SYNC1 : stream sync bytes (0xA5, 0x5A)
//   FB_HDR_LEN        : header length in bytes (sync0, sync1, X_MAX, Y_MAX)
//   dump_state_e      : dump FSM states of fb_uart_dump
//   tx_state_e        : handshake states of fb_uart_byte_sender
//   byte_kind_e       : source of the byte currently being sent
//   hdr_byte()        : header byte for a given header index
package fb_pkg;

  localparam logic [7:0]  FB_SYNC0   = 8'hA5;
  localparam logic [7:0]  FB_SYNC1   = 8'h5A;
  localparam int unsigned FB_HDR_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_HI,
    ST_RD_LO,
    ST_SEND,
    ST_WAIT,
    ST_TRAILER,
    ST_FIN
  } dump_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  typedef enum logic [1:0] {
    BK_HDR,
    BK_PIX,
    BK_CKSUM
  } byte_kind_e;

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx,
                                          input logic [7:0] x_max,
                                          input logic [7:0] y_max);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FB_SYNC0;
      2'd1:    b = FB_SYNC1;
      2'd2:    b = x_max;
      default: b = y_max;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fb_uart_byte_sender.sv
// fb_uart_byte_sender: one-byte handshake towards uart_tx.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   send_i        : 1-cycle request, accepted in idle; data_i latched then
//   data_i        : byte to send
//   tx_busy_i     : uart_tx busy
//   tx_start_o    : 1-cycle start pulse, only issued while tx_busy_i=0
//   tx_data_o     : latched byte, stable until the next accepted send
//   sent_o        : 1-cycle pulse once the byte has left (busy fell, or
//                   busy never rose within 2 cycles)
module fb_uart_byte_sender
  import fb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       send_i,
  input  logic [7:0] data_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       sent_o
);

  tx_state_e  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       tmo_q, tmo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      data_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    tx_start_o = 1'b0;
    sent_o     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (send_i) begin
          data_d  = data_i;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          tmo_d      = 1'b0;
          state_d    = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        // uart_tx that never raises busy is treated as done after 2 cycles
        if (tx_busy_i) begin
          state_d = TX_WAIT_LO;
        end else if (tmo_q) begin
          sent_o  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          tmo_d = 1'b1;
        end
      end
      TX_WAIT_LO: begin
        if (!tx_busy_i) begin
          sent_o  = 1'b1;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_data_o = data_q;

endmodule

// File: rtl/fb_uart_dump.sv
// fb_uart_dump: streams the 4-bit frame buffer over uart_tx.
//   Stream: A5 5A X_MAX Y_MAX, then X_MAX*Y_MAX/2 bytes {pix[2k], pix[2k+1]}.
//   Optional macro FB_DUMP_CKSUM_EN appends a modulo-256 sum of pixel bytes.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start / busy/done : dump request, activity flag, end-of-dump pulse
//   mem_req/mem_gnt   : shared BRAM port request and arbiter grant
//   mem_addr/mem_dout : BRAM address (BASE + pixel index), read data (+1 cycle)
//   tx_start/tx_data  : uart_tx start pulse and byte
//   tx_busy           : uart_tx busy
module fb_uart_dump
  import fb_pkg::*;
#(
  parameter int unsigned X_MAX  = 160,
  parameter int unsigned Y_MAX  = 80,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_dout,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy
);

  localparam int unsigned N  = X_MAX * Y_MAX;
  localparam int unsigned PW = $clog2(N + 1);

  dump_state_e      state_q, state_d;
  byte_kind_e       kind_q, kind_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [1:0]       hdr_idx_q, hdr_idx_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_hi_q, rd_hi_d;
  logic             send;
  logic             sent;
  logic [7:0]       tx_byte;
`ifdef FB_DUMP_CKSUM_EN
  logic [7:0]       cksum_q, cksum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      kind_q    <= BK_HDR;
      pix_q     <= '0;
      hdr_idx_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_hi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      pix_q     <= pix_d;
      hdr_idx_q <= hdr_idx_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rd_vld_q  <= rd_vld_d;
      rd_hi_q   <= rd_hi_d;
    end
  end

`ifdef FB_DUMP_CKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) cksum_q <= '0;
    else     cksum_q <= cksum_d;
  end
`endif

  always_comb begin
    case (kind_q)
      BK_HDR:   tx_byte = hdr_byte(hdr_idx_q, 8'(X_MAX), 8'(Y_MAX));
      BK_PIX:   tx_byte = {hi_q, lo_q};
`ifdef FB_DUMP_CKSUM_EN
      BK_CKSUM: tx_byte = cksum_q;
`endif
      default:  tx_byte = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pix_d     = pix_q;
    hdr_idx_d = hdr_idx_q;
    rd_vld_d  = 1'b0;
    rd_hi_d   = rd_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mem_req   = 1'b0;
    send      = 1'b0;
`ifdef FB_DUMP_CKSUM_EN
    cksum_d   = cksum_q;
`endif

    // Read data arrives the cycle after a granted address, whatever the state.
    if (rd_vld_q) begin
      if (rd_hi_q) hi_d = mem_dout;
      else         lo_d = mem_dout;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pix_d     = '0;
          hdr_idx_d = '0;
          kind_d    = BK_HDR;
          state_d   = ST_HDR;
`ifdef FB_DUMP_CKSUM_EN
          cksum_d   = '0;
`endif
        end
      end
      ST_HDR: begin
        kind_d  = BK_HDR;
        state_d = ST_SEND;
      end
      ST_RD_HI: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          pix_d    = pix_q + 1'b1;
          rd_vld_d = 1'b1;
          rd_hi_d  = 1'b1;
          state_d  = ST_RD_LO;
        end
      end
      ST_RD_LO: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          pix_d    = pix_q + 1'b1;
          rd_vld_d = 1'b1;
          rd_hi_d  = 1'b0;
          kind_d   = BK_PIX;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        // wait out the low-nibble capture before handing the byte over
        if (!rd_vld_q) begin
          send    = 1'b1;
          state_d = ST_WAIT;
`ifdef FB_DUMP_CKSUM_EN
          if (kind_q == BK_PIX) cksum_d = cksum_q + tx_byte;
`endif
        end
      end
      ST_WAIT: begin
        if (sent) begin
          case (kind_q)
            BK_HDR: begin
              if (hdr_idx_q == 2'(FB_HDR_LEN - 1)) begin
                state_d = ST_RD_HI;
              end else begin
                hdr_idx_d = hdr_idx_q + 1'b1;
                state_d   = ST_HDR;
              end
            end
            BK_PIX: begin
              if (pix_q == PW'(N)) begin
`ifdef FB_DUMP_CKSUM_EN
                state_d = ST_TRAILER;
`else
                state_d = ST_FIN;
`endif
              end else begin
                state_d = ST_RD_HI;
              end
            end
            default: state_d = ST_FIN;
          endcase
        end
      end
      ST_TRAILER: begin
        kind_d  = BK_CKSUM;
        state_d = ST_SEND;
      end
      ST_FIN: begin
        pix_d     = '0;
        hdr_idx_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign mem_addr = ADDR_W'(BASE) + ADDR_W'(pix_q);

  fb_uart_byte_sender u_sender (
    .clk_i      (clk),
    .rst_i      (rst),
    .send_i     (send),
    .data_i     (tx_byte),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_data_o  (tx_data),
    .sent_o     (sent)
  );

endmodule

// File: tb/tb_fb_uart_dump.sv
// Self-checking bench for fb_uart_dump (reduced 16x8 frame, BASE offset 100).
module tb_fb_uart_dump;

  localparam int unsigned TX    = 16;
  localparam int unsigned TY    = 8;
  localparam int unsigned TN    = TX * TY;
  localparam int unsigned TAW   = 15;
  localparam int unsigned TBASE = 100;
  localparam int unsigned LIMIT = 20000;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic           mem_req;
  logic           mem_gnt = 1'b1;
  logic [TAW-1:0] mem_addr;
  logic [3:0]     mem_dout;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;

  always #5 clk = ~clk;

  fb_uart_dump #(
    .X_MAX (TX),
    .Y_MAX (TY),
    .WIDTH (4),
    .ADDR_W(TAW),
    .BASE  (TBASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .mem_req (mem_req),
    .mem_gnt (mem_gnt),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [3:0]  pix [TN];
  logic [7:0]  rxq[$];
  logic [7:0]  expq[$];
  int unsigned busy_len   = 10;
  bit          gnt_rand   = 1'b0;
  bit          chk_stable = 1'b1;
  int unsigned done_cnt   = 0;
  int unsigned bcnt       = 0;
  int unsigned addr_err   = 0;
  int unsigned req_err    = 0;
  int unsigned start_busy = 0;
  int unsigned unstable   = 0;
  int unsigned dbl_start  = 0;
  logic [7:0]     cur_byte   = '0;
  logic           prev_start = 1'b0;
  logic [TAW-1:0] a_q        = TAW'(TBASE);
  logic           ok_q       = 1'b1;

  // BRAM: data one cycle after a granted address, garbage otherwise
  always @(posedge clk) begin
    if (mem_req && mem_gnt && mem_addr >= TAW'(TBASE) && mem_addr < TAW'(TBASE + TN))
      mem_dout <= pix[int'(mem_addr) - int'(TBASE)];
    else
      mem_dout <= 4'($urandom);
  end

  // uart_tx: captures the byte on tx_start, busy for busy_len cycles (0 = never busy)
  always @(posedge clk) begin
    prev_start <= tx_start;
    if (tx_start && prev_start) dbl_start++;
    if (tx_start) begin
      if (tx_busy) start_busy++;
      rxq.push_back(tx_data);
      cur_byte <= tx_data;
      if (busy_len > 0) begin
        tx_busy <= 1'b1;
        bcnt    <= busy_len;
      end
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      bcnt    <= 0;
      tx_busy <= 1'b0;
    end
    if (tx_busy && !tx_start && chk_stable && tx_data !== cur_byte) unstable++;
    if (done) done_cnt++;
  end

  // Address may only move after a granted read, the FIN cycle, or reset.
  always @(posedge clk) begin
    ok_q <= (mem_req && mem_gnt) || done || rst;
    a_q  <= mem_addr;
  end

  always @(negedge clk) begin
    if (mem_addr !== a_q && !ok_q) addr_err++;
    if (mem_req && !busy) req_err++;
    mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic fill(input int unsigned kind);
    for (int i = 0; i < int'(TN); i++) begin
      case (kind)
        0:       pix[i] = 4'h3;
        1:       pix[i] = 4'(i % 16);
        3:       pix[i] = 4'h1;
        default: pix[i] = 4'($urandom);
      endcase
    end
  endtask

  task automatic build_exp();
    logic [7:0] b;
    logic [7:0] sum;
    sum = '0;
    expq.delete();
    expq.push_back(8'hA5);
    expq.push_back(8'h5A);
    expq.push_back(8'(TX));
    expq.push_back(8'(TY));
    for (int k = 0; k < int'(TN / 2); k++) begin
      b = {pix[2 * k], pix[2 * k + 1]};
      expq.push_back(b);
      sum = sum + b;
    end
`ifdef FB_DUMP_CKSUM_EN
    expq.push_back(sum);
`endif
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy_after_start"}, 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input string tag, input int unsigned blen, input bit rgnt, input bit repulse);
    int unsigned cyc;
    int unsigned d0;
    busy_len = blen;
    gnt_rand = rgnt;
    build_exp();
    rxq.delete();
    d0 = done_cnt;
    pulse_start(tag);
    cyc = 0;
    while (done_cnt == d0 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (repulse && busy && $urandom_range(0, 19) == 0) start = 1'b1;
      if (repulse && done) start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy_after_done"}, 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    check({tag, ":done_count"}, done_cnt - d0, 32'd1);
    check({tag, ":idle_after"}, 32'(busy), 32'd0);
    check({tag, ":byte_count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      check($sformatf("%s:byte%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
  endtask

  initial begin
    int unsigned cyc;
    int unsigned d0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:mem_req", 32'(mem_req), 32'd0);
    check("rst:mem_addr", 32'(mem_addr), 32'(TBASE));
    check("rst:tx_start", 32'(tx_start), 32'd0);
    check("rst:tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    fill(0);
    run_frame("const3", 10, 1'b0, 1'b0);

    fill(1);
    run_frame("ramp", 4, 1'b0, 1'b0);
    if (rxq.size() > 12) begin
      check("ramp:pixbyte0", 32'(rxq[4]), 32'h01);
      check("ramp:pixbyte7", 32'(rxq[11]), 32'hEF);
      check("ramp:pixbyte8", 32'(rxq[12]), 32'h01);
    end

    fill(2);
    run_frame("gnt_rand", 6, 1'b1, 1'b0);

    fill(2);
    run_frame("restart", 3, 1'b0, 1'b1);

    fill(1);
    run_frame("no_busy", 0, 1'b1, 1'b0);

    // reset in the middle of a pixel byte
    fill(2);
    busy_len = 7;
    gnt_rand = 1'b1;
    rxq.delete();
    d0 = done_cnt;
    pulse_start("midrst");
    cyc = 0;
    while (rxq.size() < 34 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst:reached", 32'(rxq.size() >= 34), 32'd1);
    chk_stable = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst:busy", 32'(busy), 32'd0);
    check("midrst:done", 32'(done), 32'd0);
    check("midrst:mem_req", 32'(mem_req), 32'd0);
    check("midrst:mem_addr", 32'(mem_addr), 32'(TBASE));
    check("midrst:tx_start", 32'(tx_start), 32'd0);
    check("midrst:tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    cyc = 0;
    while (tx_busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check("midrst:no_done", done_cnt - d0, 32'd0);
    chk_stable = 1'b1;
    run_frame("after_rst", 7, 1'b1, 1'b0);

    fill(3);
    run_frame("ones", 5, 1'b0, 1'b0);
`ifdef FB_DUMP_CKSUM_EN
    if (rxq.size() == 4 + TN / 2 + 1)
      check("ones:trailer", 32'(rxq[4 + TN / 2]), 32'h40);
`endif

    check("mon:addr_moves_on_grant", addr_err, 32'd0);
    check("mon:req_while_idle", req_err, 32'd0);
    check("mon:start_while_busy", start_busy, 32'd0);
    check("mon:tx_data_unstable", unstable, 32'd0);
    check("mon:tx_start_width", dbl_start, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
